// File: rtl/accum_pkg.sv
// Shared constants and types for the accumulation-buffer writeback streamer.
package accum_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int BANK_ADDR_WIDTH = 7;
    localparam int BANK_DEPTH      = 128;
    localparam int CNT_W           = BANK_ADDR_WIDTH + 1;
    localparam int FIFO_DEPTH      = 4;
    localparam int FIFO_PTR_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } wb_state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/accum_wb_streamer_if.sv
// Writeback-bank read port plus the valid/ready output stream of the streamer.
interface accum_wb_streamer_if;
    import accum_pkg::*;

    logic                       ren_wb;
    logic [BANK_ADDR_WIDTH-1:0] radr_wb;
    logic [DATA_WIDTH-1:0]      rdata_wb;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       out_last;

    modport master (
        output ren_wb, radr_wb, out_valid, out_data, out_last,
        input  rdata_wb, out_ready
    );

    modport slave (
        input  ren_wb, radr_wb, out_valid, out_data, out_last,
        output rdata_wb, out_ready
    );

endinterface

// File: rtl/accum_wb_streamer_fifo.sv
// Small synchronous FIFO buffering read data between the bank port and the output stream.
module wb_skid_fifo
    import accum_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  fifo_entry_t         push_entry,
    input  logic                pop,
    output logic [FIFO_PTR_W:0] occ,
    output logic                empty,
    output logic                full,
    output fifo_entry_t         head
);

    localparam logic [FIFO_PTR_W:0] DEPTH_L = FIFO_DEPTH[FIFO_PTR_W:0];

    fifo_entry_t             mem_q [FIFO_DEPTH];
    fifo_entry_t             mem_d [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W:0]     occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + FIFO_PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
        end
        occ_d = occ_q + {{FIFO_PTR_W{1'b0}}, push} - {{FIFO_PTR_W{1'b0}}, pop};
    end

    // Storage is cleared on reset so the output word reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ   = occ_q;
    assign empty = (occ_q == '0);
    assign full  = (occ_q == DEPTH_L);
    assign head  = mem_q[rd_ptr_q];

    push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/accum_wb_streamer.sv
// Streams a finished tile out of the writeback bank: sequential reads, FIFO, valid/ready output.
module accum_wb_streamer
    import accum_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_words,
    output logic                  busy,
    output logic                  done,
    accum_wb_streamer_if.master   bus
);

    wb_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   issue_adr_q, issue_adr_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;
    logic               done_q, done_d;

    logic               room;
    logic               is_last_adr;
    logic               issue_ok;
    logic               pop;
    logic [FIFO_PTR_W:0] fifo_occ;
    logic               fifo_empty;
    logic               fifo_full;
    fifo_entry_t        fifo_head;
    fifo_entry_t        push_entry;

    // Issue depends only on registered state so ren_wb never sees out_ready combinationally.
    always_comb begin
        room        = !fifo_full && ((int'(fifo_occ) + int'(inflight_q)) < FIFO_DEPTH);
        is_last_adr = (issue_adr_q == (cnt_q - CNT_W'(1)));
        issue_ok    = (state_q == RUN) && (issue_adr_q < cnt_q) && room;
        pop         = !fifo_empty && bus.out_ready;

        state_d         = state_q;
        cnt_d           = cnt_q;
        issue_adr_d     = issue_adr_q;
        inflight_d      = issue_ok;
        inflight_last_d = issue_ok && is_last_adr;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        cnt_d       = num_words;
                        issue_adr_d = '0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_ok) begin
                    issue_adr_d = issue_adr_q + CNT_W'(1);
                    if (is_last_adr) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_head.last && (fifo_occ == (FIFO_PTR_W+1)'(1)) && !inflight_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            issue_adr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            issue_adr_q     <= issue_adr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    assign push_entry = '{last: inflight_last_q, data: bus.rdata_wb};

    wb_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop        (pop),
        .occ        (fifo_occ),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .head       (fifo_head)
    );

    assign bus.ren_wb    = issue_ok;
    assign bus.radr_wb   = issue_adr_q[BANK_ADDR_WIDTH-1:0];
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head.data;
    assign bus.out_last  = fifo_head.last;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_accum_wb_streamer.sv
// Scoreboard bench for accum_wb_streamer: bank model, expected-word queue and a negedge monitor.
module tb_accum_wb_streamer;
    import accum_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic             busy;
    logic             done;

    accum_wb_streamer_if bus();

    accum_wb_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] bank [BANK_DEPTH];
    logic [DATA_WIDTH:0]   exp_q [$];
    logic [DATA_WIDTH:0]   exp_w;
    int  checks = 0;
    int  failures = 0;
    int  exp_radr = 0;
    int  rd_count = 0;
    int  hs_count = 0;
    int  done_count = 0;
    int  outstanding = 0;
    int  max_outstanding = 0;
    bit  zero_flag = 0;
    bit  last_hs_prev = 0;
    bit  exp_done;
    bit  hs;
    bit  rand_mode = 0;
    bit  ready_cmd = 1;

    initial begin
        for (int i = 0; i < BANK_DEPTH; i++) begin
            bank[i] = 64'(i) * 64'd3 + 64'd1;
        end
    end

    // Bank read port with one cycle of latency.
    always @(posedge clk) begin
        if (bus.ren_wb) bus.rdata_wb <= bank[bus.radr_wb];
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) bus.out_ready = ($urandom_range(0, 1) == 1);
        else           bus.out_ready = ready_cmd;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives a one-cycle start and, if the DUT is idle, records the expected response.
    task automatic applyStimulus(input int n);
        bit accepted;
        @(posedge clk); #1;
        accepted  = !busy;
        start     = 1'b1;
        num_words = CNT_W'(n);
        if (accepted && n > 0) begin
            exp_radr = 0;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({(i == n - 1), bank[i]});
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (accepted && n == 0) zero_flag = 1;
    endtask

    task automatic waitDone(input string name, input int budget);
        int base;
        bit got;
        base = done_count;
        got  = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #1;
            if (done_count > base) got = 1;
        end
        checkOutput(name, 64'(got), 64'd1);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks done/radr timing.
    always @(negedge clk) begin
        if (rst) begin
            last_hs_prev = 0;
            zero_flag    = 0;
            outstanding  = 0;
        end else begin
            exp_done  = last_hs_prev || zero_flag;
            zero_flag = 0;
            if (done || exp_done) checkOutput("done_pulse", 64'(done), 64'(exp_done));
            if (done) done_count++;
            if (bus.ren_wb) begin
                checkOutput("radr", 64'(bus.radr_wb), 64'(exp_radr));
                exp_radr++;
                rd_count++;
                outstanding++;
            end
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                hs_count++;
                outstanding--;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", 64'd1, 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    checkOutput("word_data", bus.out_data, exp_w[63:0]);
                    checkOutput("word_last", 64'(bus.out_last), 64'(exp_w[64]));
                end
            end
            if (outstanding > max_outstanding) max_outstanding = outstanding;
            last_hs_prev = hs && bus.out_last;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  base;
        int  db;
        bit  have;
        bit  saw;
        bit  reached;
        logic [63:0] held;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_ren", 64'(bus.ren_wb), 64'd0);
        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_last", 64'(bus.out_last), 64'd0);
        checkOutput("rst_radr", 64'(bus.radr_wb), 64'd0);
        checkOutput("rst_data", bus.out_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] T1 basic");
        applyStimulus(8);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk); #1;
            checkOutput("t1_ren_run", 64'(bus.ren_wb), (k <= 8) ? 64'd1 : 64'd0);
            if (k == 2) checkOutput("t1_valid_early", 64'(bus.out_valid), 64'd0);
            if (k == 3) checkOutput("t1_valid_latency", 64'(bus.out_valid), 64'd1);
        end
        waitDone("t1_done", 40);
        checkOutput("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] T2 zero");
        applyStimulus(0);
        saw = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            saw = saw | bus.ren_wb | bus.out_valid | busy;
        end
        checkOutput("t2_no_activity", 64'(saw), 64'd0);

        $display("[TB] T3 backpressure");
        ready_cmd = 0;
        base = rd_count;
        applyStimulus(16);
        have = 0;
        held = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (bus.out_valid) begin
                if (!have) begin
                    held = bus.out_data;
                    have = 1;
                end else begin
                    checkOutput("t3_data_stable", bus.out_data, held);
                end
            end
        end
        checkOutput("t3_reads_stalled", 64'(rd_count - base), 64'd4);
        checkOutput("t3_valid_held", 64'(bus.out_valid), 64'd1);
        ready_cmd = 1;
        waitDone("t3_done", 200);
        checkOutput("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] T4 random ready");
        max_outstanding = 0;
        rand_mode = 1;
        applyStimulus(128);
        waitDone("t4_done", 3000);
        rand_mode = 0;
        checkOutput("t4_outstanding_le4", 64'(max_outstanding <= FIFO_DEPTH), 64'd1);
        checkOutput("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] T5 ignored start");
        db = done_count;
        applyStimulus(12);
        repeat (3) @(negedge clk);
        applyStimulus(5);
        waitDone("t5_done", 100);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("t5_one_done", 64'(done_count - db), 64'd1);
        checkOutput("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] T6 reset mid-run");
        base = hs_count;
        applyStimulus(20);
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk); #1;
            if (hs_count - base >= 6) reached = 1;
        end
        checkOutput("t6_reached_word6", 64'(reached), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        db = done_count;
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t6_ren", 64'(bus.ren_wb), 64'd0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("t6_no_done", 64'(done_count - db), 64'd0);
        applyStimulus(3);
        waitDone("t6_restart_done", 40);
        checkOutput("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
